pulse_delay_checker: RTL and testbench

//   Receive-side checker for the delayed single-pulse generator. After a trigger
//   (start), measures cycles until the response pulse rises (delay) and how many

---
 rtl/pulse_delay_checker_pkg.sv | 12 +
 rtl/pulse_edge_det.sv | 19 +
 rtl/pulse_delay_checker.sv | 110 +++++++++++
 tb/tb_pulse_delay_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_delay_checker_pkg.sv
// pulse_delay_checker_pkg: FSM state encodings and default pulse timing shared with the generator.
package pulse_delay_checker_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam int DEF_EXP_DELAY = 10;
    localparam int DEF_EXP_WIDTH = 1;

endpackage

// File: rtl/pulse_edge_det.sv
// pulse_edge_det: registers din every cycle and flags its low->high and high->low transitions.
module pulse_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) din_d <= 1'b0;
        else        din_d <= din;

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/pulse_delay_checker.sv
// pulse_delay_checker: measures start-to-rise delay and pulse width on din and
// checks both against the expected values, reporting done/pass/error flags.
module pulse_delay_checker
    import pulse_delay_checker_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int EXP_DELAY = DEF_EXP_DELAY,
    parameter int DELAY_TOL = 0,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int TIMEOUT   = 255,
    parameter int MAX_WIDTH = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_timeout,
    output logic             err_width,
    output logic [CNT_W-1:0] delay_cnt,
    output logic [CNT_W-1:0] width_cnt
);

    localparam logic signed [CNT_W:0] EXP_D = (CNT_W+1)'(EXP_DELAY);
    localparam logic signed [CNT_W:0] TOL   = (CNT_W+1)'(DELAY_TOL);
    localparam logic [CNT_W-1:0]      EXP_W = CNT_W'(EXP_WIDTH);
    localparam logic [CNT_W-1:0]      TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      MAX_W = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0]      ONE   = CNT_W'(1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        dcnt;
    logic [CNT_W-1:0]        wcnt;
    logic [CNT_W-1:0]        wcnt_n;
    logic                    rise;
    logic                    fall;
    logic signed [CNT_W:0]   diff;
    logic                    delay_ok;

    pulse_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .rise  (rise),
        .fall  (fall)
    );

    // din_d is always 1 while in HIGH, so fall is exactly "din sampled low"
    assign wcnt_n   = wcnt + ONE;
    assign diff     = $signed({1'b0, delay_cnt}) - EXP_D;
    assign delay_ok = (diff <= TOL) && (-diff <= TOL);
    assign busy     = state != S_IDLE;
    assign done     = state == S_REPORT;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= S_IDLE;
            dcnt        <= '0;
            wcnt        <= '0;
            pass        <= 1'b0;
            err_timeout <= 1'b0;
            err_width   <= 1'b0;
            delay_cnt   <= '0;
            width_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (start) begin
                        state       <= S_WAIT;
                        dcnt        <= ONE;
                        pass        <= 1'b0;
                        err_timeout <= 1'b0;
                        err_width   <= 1'b0;
                        delay_cnt   <= '0;
                        width_cnt   <= '0;
                    end
                S_WAIT:
                    if (rise) begin
                        state     <= S_HIGH;
                        delay_cnt <= dcnt;
                        wcnt      <= ONE;
                    end else if (dcnt == TO) begin
                        state       <= S_REPORT;
                        err_timeout <= 1'b1;
                        delay_cnt   <= '0;
                    end else begin
                        dcnt <= dcnt + ONE;
                    end
                S_HIGH:
                    if (fall) begin
                        state     <= S_REPORT;
                        width_cnt <= wcnt;
                        err_width <= wcnt != EXP_W;
                        pass      <= delay_ok && (wcnt == EXP_W);
                    end else begin
                        wcnt <= wcnt_n;
                        if (wcnt_n == MAX_W) begin
                            state     <= S_REPORT;
                            err_width <= 1'b1;
                            width_cnt <= MAX_W;
                        end
                    end
                default:
                    state <= S_IDLE;
            endcase
        end

endmodule

// File: tb/tb_pulse_delay_checker.sv
// tb_pulse_delay_checker: table-driven directed checks of two checker instances
// (default parameters, and TIMEOUT=20 / DELAY_TOL=1 / MAX_WIDTH=4) on shared stimulus.
module tb_pulse_delay_checker;

    typedef struct {
        int at;
        int d;
        int w;
        int p;
        int et;
        int ew;
    } res_t;

    typedef struct {
        int   rise;
        int   w;
        int   pre;
        int   s2;
        res_t a;
        res_t b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic [1:0] busy, done, pass, et, ew;
    logic [7:0] dly [2];
    logic [7:0] wid [2];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pulse_delay_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_timeout(et[0]), .err_width(ew[0]),
        .delay_cnt(dly[0]), .width_cnt(wid[0])
    );

    pulse_delay_checker #(.TIMEOUT(20), .DELAY_TOL(1), .MAX_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_timeout(et[1]), .err_width(ew[1]),
        .delay_cnt(dly[1]), .width_cnt(wid[1])
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    endtask

    task automatic chk_zero(input string n);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.%0d.busy", n, i), busy[i], 0);
            chk($sformatf("%s.%0d.done", n, i), done[i], 0);
            chk($sformatf("%s.%0d.pass", n, i), pass[i], 0);
            chk($sformatf("%s.%0d.et", n, i), et[i], 0);
            chk($sformatf("%s.%0d.ew", n, i), ew[i], 0);
            chk($sformatf("%s.%0d.dly", n, i), dly[i], 0);
            chk($sformatf("%s.%0d.wid", n, i), wid[i], 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        din   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic pat(input vec_t v, input int j);
        return (v.rise > 0 && j >= v.rise && j < v.rise + v.w) || (j < v.pre);
    endfunction

    // offset j = number of edges after the edge that samples start
    task automatic run(input string n, input vec_t v);
        int   at [2];
        int   nd [2];
        res_t e;
        at = '{-1, -1};
        nd = '{0, 0};
        @(negedge clk);
        start = 1'b1;
        din   = pat(v, 0);
        for (int j = 1; j <= 46; j++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (done[i]) begin
                    nd[i]++;
                    if (at[i] < 0) at[i] = j - 1;
                end
            start = (v.s2 != 0) && (j == v.s2);
            din   = pat(v, j);
        end
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? v.a : v.b;
            chk($sformatf("%s.%0d.done_at", n, i), at[i], e.at);
            chk($sformatf("%s.%0d.done_n", n, i), nd[i], (e.at < 0) ? 0 : 1);
            chk($sformatf("%s.%0d.busy", n, i), busy[i], (e.at < 0) ? 1 : 0);
            chk($sformatf("%s.%0d.dly", n, i), dly[i], e.d);
            chk($sformatf("%s.%0d.wid", n, i), wid[i], e.w);
            chk($sformatf("%s.%0d.pass", n, i), pass[i], e.p);
            chk($sformatf("%s.%0d.et", n, i), et[i], e.et);
            chk($sformatf("%s.%0d.ew", n, i), ew[i], e.ew);
        end
    endtask

    vec_t tbl [11];
    vec_t lb;
    int   nd_rst;

    initial begin
        lb = '{rise: 10, w: 1, pre: 0, s2: 0,
               a: '{11, 10, 1, 1, 0, 0}, b: '{11, 10, 1, 1, 0, 0}};
        tbl[0]  = lb;
        tbl[1]  = '{0, 0, 0, 0, '{-1, 0, 0, 0, 0, 0}, '{20, 0, 0, 0, 1, 0}};
        tbl[2]  = '{10, 3, 0, 0, '{13, 10, 3, 0, 0, 1}, '{13, 10, 3, 0, 0, 1}};
        tbl[3]  = '{11, 1, 0, 0, '{12, 11, 1, 0, 0, 0}, '{12, 11, 1, 1, 0, 0}};
        tbl[4]  = '{12, 1, 0, 0, '{13, 12, 1, 0, 0, 0}, '{13, 12, 1, 0, 0, 0}};
        tbl[5]  = '{10, 1, 5, 0, '{11, 10, 1, 1, 0, 0}, '{11, 10, 1, 1, 0, 0}};
        tbl[6]  = '{10, 6, 0, 0, '{16, 10, 6, 0, 0, 1}, '{13, 10, 4, 0, 0, 1}};
        tbl[7]  = '{3, 2, 0, 0, '{5, 3, 2, 0, 0, 1}, '{5, 3, 2, 0, 0, 1}};
        tbl[8]  = '{1, 1, 0, 0, '{2, 1, 1, 0, 0, 0}, '{2, 1, 1, 0, 0, 0}};
        tbl[9]  = lb;
        tbl[9].s2  = 5;
        tbl[10] = lb;
        tbl[10].s2 = 12;

        @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 11; r++) begin
            run($sformatf("v%0d", r), tbl[r]);
            do_reset();
        end

        // reset while the pulse is high aborts without a done strobe
        @(negedge clk);
        start = 1'b1;
        din   = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            start = 1'b0;
            din   = (j >= 10);
        end
        chk("mid.busy", busy[0], 1);
        chk("mid.dly", dly[0], 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        nd_rst = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            din = 1'b0;
            if (done[0] | done[1]) nd_rst++;
        end
        chk("mid_rst.done_n", nd_rst, 0);
        rst_n = 1'b1;
        run("after_rst", lb);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
